cache_ram_responder: RTL and testbench
======================================

CACHE_RAM_RESPONDER -- requirements
Module: cache_ram_responder

Interface
REQ-001 Parameter: ADDR_WIDTH, default 32, byte-address width.
REQ-002 Parameter: DATA_WIDTH, default 32, word width; a line is 4 words (4*DATA_WIDTH bits).
REQ-003 Port: clk  in  1  single clock, all logic rising-edge.
REQ-004 Port: rst  in  1  reset; synchronous, active-high.
REQ-005 Port: cache_rd_req_i  in  1  line refill request, level, held by the cache until the last word returns.
REQ-006 Port: cache_rd_addr_i  in  ADDR_WIDTH  refill byte address.
REQ-007 Port: cache_rd_rdy_o  out  1  refill word valid strobe.
REQ-008 Port: cache_rd_data_o  out  DATA_WIDTH  refill word.
REQ-009 Port: cache_rd_num_o  out  3  index of the word on cache_rd_data_o, 0-3; bit 2 always 0.
REQ-010 Port: cache_wr_req_i  in  1  writeback request, level.
REQ-011 Port: cache_wr_addr_i  in  ADDR_WIDTH  writeback line address.
REQ-012 Port: cache_wr_data_i  in  4*DATA_WIDTH  victim line, word k at bits [32k+31:32k].
REQ-013 Port: cache_dirty_i  in  1  victim line dirty qualifier.
REQ-014 Port: cache_wr_rdy_o  out  1  responder can accept a writeback.
REQ-015 Port: ram_wr_en_o  out  4  RAM byte write enables.
REQ-016 Port: ram_wr_addr_o / ram_wr_data_o  out  ADDR_WIDTH / DATA_WIDTH  RAM write address / data.
REQ-017 Port: ram_rd_addr_o  out  ADDR_WIDTH  RAM read address; ram_rd_data_i  in  DATA_WIDTH  data, valid exactly 1 cycle after the address.

Function
REQ-018 FSM states: IDLE, WR, RD_ADDR, RD_LAST, DONE; requests are sampled only in IDLE.
REQ-019 IDLE with both requests: writeback served first; refill served after DONE.
REQ-020 IDLE, cache_wr_req_i=1, cache_dirty_i=1: latch line and address with bits [3:0] cleared, go to WR.
REQ-021 IDLE, cache_wr_req_i=1, cache_dirty_i=0: no RAM write, go directly to DONE.
REQ-022 WR: 4 cycles, cycle k drives ram_wr_en_o=4'hF, ram_wr_addr_o=base+4k, ram_wr_data_o=word k; then DONE.
REQ-023 IDLE, cache_rd_req_i=1 (and no writeback): latch line-aligned base and word offset addr[3:2], go to RD_ADDR.
REQ-024 RD_ADDR: 4 cycles, cycle j drives ram_rd_addr_o=base+4*w(j); then RD_LAST (1 cycle); then DONE.
REQ-025 Cycle after each RD_ADDR cycle: cache_rd_rdy_o=1, cache_rd_data_o=ram_rd_data_i (registered or passthrough, timing fixed per REQ-026), cache_rd_num_o=w(j).
REQ-026 Latency: request sampled at cycle 0; word strobes at cycles 2,3,4,5; DONE at cycle 6; next request sampled at cycle 7 earliest.
REQ-027 DONE: one cycle, ignores requests so the cache can deassert its level request.
REQ-028 cache_wr_rdy_o=1 only in IDLE.
REQ-029 Outside WR: ram_wr_en_o=0; outside RD_ADDR: ram_rd_addr_o=0; outside strobe cycles: cache_rd_rdy_o=0, cache_rd_num_o=0, cache_rd_data_o=0.
REQ-030 Word counter is 2 bits and wraps 3->0; address arithmetic is ADDR_WIDTH modulo 2^ADDR_WIDTH.
REQ-031 Latched address/data are stable for the whole transaction regardless of input changes.

Reset
REQ-032 rst=1 at a clock edge: state IDLE, counters 0, all outputs 0 except cache_wr_rdy_o=1 from the following cycle.
REQ-033 rst mid-transaction: abandon; no RAM write and no rd strobe in the cycle after the reset edge.

Configuration
REQ-034 Macro CRITICAL_WORD_FIRST_EN defined: w(j)=(addr[3:2]+j) mod 4, i.e. requested word first, wrapping.
REQ-035 Macro undefined: w(j)=j, i.e. always words 0,1,2,3; addr[3:2] ignored.

Verification
REQ-036 Refill addr 0x0000_1008, RAM word[i]=0xA000_0000+i at 0x1000+4i, macro off -> strobes cycles 2-5, num 0,1,2,3, data 0xA000_0400..0xA000_0403 (0x1000/4=0x400).
REQ-037 Same, macro on -> num 2,3,0,1, data 0xA000_0402,0xA000_0403,0xA000_0400,0xA000_0401.
REQ-038 Writeback addr 0x2004, dirty=1, line 0x44..4_33..3_22..2_11..1 -> 4 writes, en=4'hF, addrs 0x2000,0x2004,0x2008,0x200C, data 0x11111111,0x22222222,0x33333333,0x44444444; wr_rdy low for 5 cycles.
REQ-039 Writeback with dirty=0 -> no ram_wr_en_o pulse, IDLE reached 2 cycles after request.
REQ-040 Rd and wr requests same cycle -> all 4 RAM writes complete before first ram_rd_addr_o.
REQ-041 rst asserted after 2nd write of REQ-038 -> no 3rd write, outputs 0, wr_rdy=1 next cycle.

Source files
------------

// File: rtl/cache_ram_responder.sv
// -----------------------------------------------------------------------------
// cache_ram_responder
//
// Purpose:
//   Sits between a cache controller and a simple word-wide synchronous RAM.
//   Serves two kinds of cache transactions one at a time:
//     * writeback : a dirty victim line of 4 words is written to RAM as four
//                   consecutive full-word writes (clean victims are dropped).
//     * refill    : a 4-word line is read from RAM and handed back to the cache
//                   one word per cycle, each word tagged with its index.
//   If both requests are present in IDLE, the writeback is served first. The
//   refill request is a held level, so it is picked up on the next IDLE.
//
// Configuration macro:
//   CRITICAL_WORD_FIRST_EN
//     defined   : refill returns the requested word (addr[3:2]) first, then
//                 wraps through the rest of the line.
//     undefined : refill always returns words 0,1,2,3 and ignores addr[3:2].
//
// Ports:
//   clk              single clock, rising edge
//   rst              synchronous active-high reset
//   cache_rd_req_i   refill request (level, held until the last word returns)
//   cache_rd_addr_i  refill byte address
//   cache_rd_rdy_o   refill word valid strobe
//   cache_rd_data_o  refill word
//   cache_rd_num_o   index of the word on cache_rd_data_o (bit 2 always 0)
//   cache_wr_req_i   writeback request (level)
//   cache_wr_addr_i  writeback line address
//   cache_wr_data_i  victim line, word k at [DATA_WIDTH*k +: DATA_WIDTH]
//   cache_dirty_i    victim line dirty qualifier
//   cache_wr_rdy_o   high only while idle and able to accept a request
//   ram_wr_en_o      RAM byte write enables
//   ram_wr_addr_o    RAM write address
//   ram_wr_data_o    RAM write data
//   ram_rd_addr_o    RAM read address
//   ram_rd_data_i    RAM read data, valid one cycle after the address
// -----------------------------------------------------------------------------
module cache_ram_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    cache_rd_req_i,
  input  logic [ADDR_WIDTH-1:0]   cache_rd_addr_i,
  output logic                    cache_rd_rdy_o,
  output logic [DATA_WIDTH-1:0]   cache_rd_data_o,
  output logic [2:0]              cache_rd_num_o,

  input  logic                    cache_wr_req_i,
  input  logic [ADDR_WIDTH-1:0]   cache_wr_addr_i,
  input  logic [4*DATA_WIDTH-1:0] cache_wr_data_i,
  input  logic                    cache_dirty_i,
  output logic                    cache_wr_rdy_o,

  output logic [3:0]              ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wr_data_o,
  output logic [ADDR_WIDTH-1:0]   ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data_i
);

  // FSM encoding
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] RD_ADDR = 3'd2;
  localparam logic [2:0] RD_LAST = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]              state;
  logic [1:0]              word_cnt;
  logic [ADDR_WIDTH-1:0]   base_addr;
  logic [4*DATA_WIDTH-1:0] line;
  logic                    strobe;
  logic [1:0]              strobe_num;

  // Word index currently being addressed during RD_ADDR
  logic [1:0]              rd_word;
  logic [DATA_WIDTH-1:0]   wr_word;
  logic [ADDR_WIDTH-1:0]   wr_offset;
  logic [ADDR_WIDTH-1:0]   rd_offset;

  // Request decode in IDLE: writeback has priority over refill
  logic                    take_wr;
  logic                    take_rd;

  assign take_wr = (state == IDLE) && cache_wr_req_i;
  assign take_rd = (state == IDLE) && !cache_wr_req_i && cache_rd_req_i;

`ifdef CRITICAL_WORD_FIRST_EN
  // Requested word offset, captured with the refill so that later address
  // changes from the cache cannot disturb the running transaction.
  logic [1:0] first_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      first_word <= 2'd0;
    end else if (take_rd) begin
      first_word <= cache_rd_addr_i[3:2];
    end
  end

  // 2-bit add wraps naturally: requested word first, then the rest in order
  assign rd_word = first_word + word_cnt;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cache_rd_addr_i[1:0], cache_wr_addr_i[3:0]};
`else
  assign rd_word = word_cnt;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cache_rd_addr_i[3:0], cache_wr_addr_i[3:0]};
`endif

  // Main FSM plus the latched transaction context. Base address and victim
  // line are captured only when a request is accepted in IDLE and then held
  // for the whole transaction. The read strobe runs one cycle behind the
  // RAM read address to line up with the RAM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_cnt   <= 2'd0;
      base_addr  <= '0;
      line       <= '0;
      strobe     <= 1'b0;
      strobe_num <= 2'd0;
    end else begin
      strobe     <= (state == RD_ADDR);
      strobe_num <= (state == RD_ADDR) ? rd_word : 2'd0;

      case (state)
        IDLE: begin
          word_cnt <= 2'd0;
          if (take_wr) begin
            base_addr <= {cache_wr_addr_i[ADDR_WIDTH-1:4], 4'h0};
            line      <= cache_wr_data_i;
            state     <= cache_dirty_i ? WR : DONE;
          end else if (take_rd) begin
            base_addr <= {cache_rd_addr_i[ADDR_WIDTH-1:4], 4'h0};
            state     <= RD_ADDR;
          end
        end

        WR: begin
          word_cnt <= word_cnt + 2'd1;
          if (word_cnt == 2'd3) begin
            state <= DONE;
          end
        end

        RD_ADDR: begin
          word_cnt <= word_cnt + 2'd1;
          if (word_cnt == 2'd3) begin
            state <= RD_LAST;
          end
        end

        // Last RAM word is arriving; just wait for it
        RD_LAST: state <= DONE;

        // One dead cycle so the cache can drop its level request
        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  // Byte offsets within the line for the current write / read word
  assign wr_offset = {{(ADDR_WIDTH-4){1'b0}}, word_cnt, 2'b00};
  assign rd_offset = {{(ADDR_WIDTH-4){1'b0}}, rd_word, 2'b00};

  // Select the victim word being written this cycle
  always_comb begin
    wr_word = '0;
    case (word_cnt)
      2'd0: wr_word = line[0*DATA_WIDTH +: DATA_WIDTH];
      2'd1: wr_word = line[1*DATA_WIDTH +: DATA_WIDTH];
      2'd2: wr_word = line[2*DATA_WIDTH +: DATA_WIDTH];
      2'd3: wr_word = line[3*DATA_WIDTH +: DATA_WIDTH];
      default: wr_word = '0;
    endcase
  end

  // Outputs are pure decodes of registered state so every output is quiet
  // outside the cycles that own it, including the cycle right after reset.
  assign cache_wr_rdy_o  = (state == IDLE);

  assign ram_wr_en_o     = (state == WR) ? 4'hF : 4'h0;
  assign ram_wr_addr_o   = (state == WR) ? (base_addr + wr_offset) : '0;
  assign ram_wr_data_o   = (state == WR) ? wr_word : '0;

  assign ram_rd_addr_o   = (state == RD_ADDR) ? (base_addr + rd_offset) : '0;

  // RAM data is passed straight through while the strobe is up
  assign cache_rd_rdy_o  = strobe;
  assign cache_rd_num_o  = {1'b0, strobe_num};
  assign cache_rd_data_o = strobe ? ram_rd_data_i : '0;

endmodule

// File: tb/tb_cache_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_cache_ram_responder
//
// Self-checking bench for cache_ram_responder. A behavioural RAM returns
// 0xA000_0000 + addr/4 one cycle after each read address. Expected outputs
// are derived per cycle from the transaction timeline: request sampled at
// cycle 0, RAM reads at cycles 1-4, word strobes at 2-5, DONE at 6, IDLE at
// 7; writebacks write at cycles 1-4, DONE at 5, IDLE at 6; clean victims go
// DONE at 1, IDLE at 2. Honors CRITICAL_WORD_FIRST_EN like the design.
// -----------------------------------------------------------------------------
module tb_cache_ram_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         cache_rd_req;
  logic [31:0]  cache_rd_addr;
  logic         cache_rd_rdy;
  logic [31:0]  cache_rd_data;
  logic [2:0]   cache_rd_num;
  logic         cache_wr_req;
  logic [31:0]  cache_wr_addr;
  logic [127:0] cache_wr_data;
  logic         cache_dirty;
  logic         cache_wr_rdy;
  logic [3:0]   ram_wr_en;
  logic [31:0]  ram_wr_addr;
  logic [31:0]  ram_wr_data;
  logic [31:0]  ram_rd_addr;
  logic [31:0]  ram_rd_data = 32'h0;

  int checks   = 0;
  int failures = 0;

  cache_ram_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .cache_rd_req_i  (cache_rd_req),
    .cache_rd_addr_i (cache_rd_addr),
    .cache_rd_rdy_o  (cache_rd_rdy),
    .cache_rd_data_o (cache_rd_data),
    .cache_rd_num_o  (cache_rd_num),
    .cache_wr_req_i  (cache_wr_req),
    .cache_wr_addr_i (cache_wr_addr),
    .cache_wr_data_i (cache_wr_data),
    .cache_dirty_i   (cache_dirty),
    .cache_wr_rdy_o  (cache_wr_rdy),
    .ram_wr_en_o     (ram_wr_en),
    .ram_wr_addr_o   (ram_wr_addr),
    .ram_wr_data_o   (ram_wr_data),
    .ram_rd_addr_o   (ram_rd_addr),
    .ram_rd_data_i   (ram_rd_data)
  );

  always #5 clk = ~clk;

  // RAM contents as a pure function of the byte address
  function automatic logic [31:0] ramWord(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  // Synchronous RAM read port: data one cycle after the address
  always @(posedge clk) ram_rd_data <= ramWord(ram_rd_addr);

  // Index of the j-th word returned for a refill of addr
  function automatic logic [1:0] wordAt(input logic [31:0] addr, input int j);
`ifdef CRITICAL_WORD_FIRST_EN
    return 2'((addr[3:2] + j) % 4);
`else
    return 2'(j);
`endif
  endfunction

  function automatic logic [31:0] lineBase(input logic [31:0] addr);
    return {addr[31:4], 4'h0};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output at one sample point
  task automatic checkCycle(input string tag, input int c,
                            input logic expWrRdy, input logic [3:0] expWrEn,
                            input logic [31:0] expWrAddr, input logic [31:0] expWrData,
                            input logic [31:0] expRdAddr, input logic expRdy,
                            input logic [2:0] expNum, input logic [31:0] expData);
    checkOutput($sformatf("%s.c%0d.wr_rdy", tag, c), 64'(cache_wr_rdy), 64'(expWrRdy));
    checkOutput($sformatf("%s.c%0d.wr_en", tag, c), 64'(ram_wr_en), 64'(expWrEn));
    if (expWrEn != 4'h0) begin
      checkOutput($sformatf("%s.c%0d.wr_addr", tag, c), 64'(ram_wr_addr), 64'(expWrAddr));
      checkOutput($sformatf("%s.c%0d.wr_data", tag, c), 64'(ram_wr_data), 64'(expWrData));
    end
    checkOutput($sformatf("%s.c%0d.rd_addr", tag, c), 64'(ram_rd_addr), 64'(expRdAddr));
    checkOutput($sformatf("%s.c%0d.rd_rdy", tag, c), 64'(cache_rd_rdy), 64'(expRdy));
    checkOutput($sformatf("%s.c%0d.rd_num", tag, c), 64'(cache_rd_num), 64'(expNum));
    checkOutput($sformatf("%s.c%0d.rd_data", tag, c), 64'(cache_rd_data), 64'(expData));
  endtask

  task automatic idleCycle(input string tag);
    @(negedge clk);
    checkCycle(tag, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 32'h0);
  endtask

  // Refill timeline after the request has been sampled at cycle 0
  task automatic waitRefill(input string tag, input logic [31:0] addr);
    logic [31:0] base;
    logic [31:0] rdAddr;
    logic        rdy;
    logic [2:0]  num;
    logic [31:0] data;
    base = lineBase(addr);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      rdAddr = 32'h0;
      rdy    = 1'b0;
      num    = 3'd0;
      data   = 32'h0;
      if (c <= 4) rdAddr = base + 32'(4 * wordAt(addr, c - 1));
      if (c >= 2 && c <= 5) begin
        rdy  = 1'b1;
        num  = {1'b0, wordAt(addr, c - 2)};
        data = ramWord(base + 32'(4 * wordAt(addr, c - 2)));
      end
      checkCycle(tag, c, c == 7, 4'h0, 32'h0, 32'h0, rdAddr, rdy, num, data);
      if (c < 6) cache_rd_addr = $urandom;
      if (c == 6) cache_rd_req = 1'b0;
    end
  endtask

  task automatic runRefill(input string tag, input logic [31:0] addr);
    cache_rd_req  = 1'b1;
    cache_rd_addr = addr;
    waitRefill(tag, addr);
  endtask

  task automatic runWriteback(input string tag, input logic [31:0] addr,
                              input logic [127:0] lineData, input logic dirty,
                              input logic alsoRd, input logic [31:0] rdAddr);
    int nW;
    logic [31:0] base;
    nW   = dirty ? 4 : 0;
    base = lineBase(addr);
    cache_wr_req  = 1'b1;
    cache_wr_addr = addr;
    cache_wr_data = lineData;
    cache_dirty   = dirty;
    if (alsoRd) begin
      cache_rd_req  = 1'b1;
      cache_rd_addr = rdAddr;
    end
    for (int c = 1; c <= nW + 2; c++) begin
      @(negedge clk);
      if (c <= nW)
        checkCycle(tag, c, 1'b0, 4'hF, base + 32'(4 * (c - 1)),
                   lineData[32*(c-1) +: 32], 32'h0, 1'b0, 3'd0, 32'h0);
      else
        checkCycle(tag, c, c == nW + 2, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 32'h0);
      cache_wr_addr = $urandom;
      cache_wr_data = {$urandom, $urandom, $urandom, $urandom};
      cache_dirty   = 1'($urandom);
      if (c == nW + 1) cache_wr_req = 1'b0;
    end
    if (alsoRd) waitRefill({tag, ".rd"}, rdAddr);
  endtask

  // Start a transaction, let two cycles run, then reset it away
  task automatic runAbort(input string tag, input logic isWrite,
                          input logic [31:0] addr, input logic [127:0] lineData);
    logic [31:0] base;
    base = lineBase(addr);
    if (isWrite) begin
      cache_wr_req  = 1'b1;
      cache_wr_addr = addr;
      cache_wr_data = lineData;
      cache_dirty   = 1'b1;
    end else begin
      cache_rd_req  = 1'b1;
      cache_rd_addr = addr;
    end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      if (isWrite)
        checkCycle(tag, c, 1'b0, 4'hF, base + 32'(4 * (c - 1)),
                   lineData[32*(c-1) +: 32], 32'h0, 1'b0, 3'd0, 32'h0);
      else
        checkCycle(tag, c, 1'b0, 4'h0, 32'h0, 32'h0,
                   base + 32'(4 * wordAt(addr, c - 1)), c == 2,
                   (c == 2) ? {1'b0, wordAt(addr, 0)} : 3'd0,
                   (c == 2) ? ramWord(base + 32'(4 * wordAt(addr, 0))) : 32'h0);
    end
    rst          = 1'b1;
    cache_wr_req = 1'b0;
    cache_rd_req = 1'b0;
    @(negedge clk);
    checkCycle(tag, 3, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 32'h0);
    rst = 1'b0;
    idleCycle({tag, ".after"});
  endtask

  // One randomized transaction of a randomly chosen kind
  task automatic applyStimulus(input int n);
    int kind;
    logic [31:0]  addr;
    logic [31:0]  addr2;
    logic [127:0] lineData;
    kind     = $urandom_range(0, 4);
    addr     = $urandom;
    addr2    = $urandom;
    lineData = {$urandom, $urandom, $urandom, $urandom};
    case (kind)
      0: runRefill($sformatf("rnd%0d.rd", n), addr);
      1: runWriteback($sformatf("rnd%0d.wrd", n), addr, lineData, 1'b1, 1'b0, 32'h0);
      2: runWriteback($sformatf("rnd%0d.wrc", n), addr, lineData, 1'b0, 1'b0, 32'h0);
      3: runWriteback($sformatf("rnd%0d.both", n), addr, lineData, 1'b1, 1'b1, addr2);
      default: runWriteback($sformatf("rnd%0d.bothc", n), addr, lineData, 1'b0, 1'b1, addr2);
    endcase
    repeat ($urandom_range(0, 2)) idleCycle($sformatf("rnd%0d.gap", n));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst           = 1'b1;
    cache_rd_req  = 1'b0;
    cache_rd_addr = 32'h0;
    cache_wr_req  = 1'b0;
    cache_wr_addr = 32'h0;
    cache_wr_data = 128'h0;
    cache_dirty   = 1'b0;
    repeat (2) @(negedge clk);
    checkCycle("reset", 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 32'h0);
    rst = 1'b0;
    idleCycle("post_reset");

    $display("[TB] directed refill 0x1008");
    runRefill("refill_1008", 32'h0000_1008);

    $display("[TB] directed dirty writeback 0x2004");
    runWriteback("wb_2004", 32'h0000_2004,
                 128'h44444444_33333333_22222222_11111111, 1'b1, 1'b0, 32'h0);

    $display("[TB] directed clean writeback");
    runWriteback("wb_clean", 32'h0000_2004,
                 128'h44444444_33333333_22222222_11111111, 1'b0, 1'b0, 32'h0);

    $display("[TB] simultaneous writeback and refill");
    runWriteback("both", 32'h0000_3000,
                 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b1, 1'b1, 32'h0000_1008);

    $display("[TB] top-of-memory refill");
    runRefill("refill_top", 32'hFFFF_FFF4);

    $display("[TB] reset during writeback and refill");
    runAbort("abort_wb", 1'b1, 32'h0000_2004, 128'h44444444_33333333_22222222_11111111);
    runAbort("abort_rd", 1'b0, 32'h0000_500C, 128'h0);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 30; n++) applyStimulus(n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
